// File: rtl/calc_param_if.sv
`default_nettype none
// ============================================================================
// Module  : calc_param_if
// Purpose : Keypad-command / display bundle between the keypad decoder
//           (master) and the calc_param calculator core (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface calc_param_if #(
  parameter int NDIG = 8,
  parameter int W    = 27
);
  localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic [W-1:0]  digits;
  logic          neg;

  modport master (output cmd, cmd_valid, input status, data, pos, digits, neg);
  modport slave  (input cmd, cmd_valid, output status, data, pos, digits, neg);
endinterface
`default_nettype wire

// File: rtl/calc_param.sv
`default_nettype none
// ============================================================================
// Module  : calc_param
// Purpose : Decimal calculator core. Builds operands from key commands,
//           runs add/sub in one cycle and mul/div as W-step shift-add /
//           restoring-divide loops, chains operators, and scans the BCD
//           digits of the current value onto a digit-multiplexed display.
//           Build macro CALC_DIV_EN: includes the divider (cmd 13 divides);
//           without it cmd 13 is an error.
// Revision: 1.0 - initial release
// ============================================================================
module calc_param #(
  parameter int NDIG = 8,
  parameter int W    = 27
) (
  input  wire logic   clk,
  input  wire logic   rst,
  calc_param_if.slave bus
);
  localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  function automatic logic [W+3:0] pow10_m1(input int n);
    logic [W+3:0] p;
    p = (W+4)'(1);
    for (int i = 0; i < n; i++) p = p * (W+4)'(10);
    return p - (W+4)'(1);
  endfunction

  localparam logic [W+3:0] LIMIT     = pow10_m1(NDIG);
  localparam logic [1:0]   ST_ERROR  = 2'b00;
  localparam logic [1:0]   ST_BUSY   = 2'b01;
  localparam logic [1:0]   ST_READY  = 2'b10;
  localparam logic [3:0]   K_ADD     = 4'd10;
  localparam logic [3:0]   K_SUB     = 4'd11;
  localparam logic [3:0]   K_MUL     = 4'd12;
  localparam logic [3:0]   K_DIV     = 4'd13;
  localparam logic [3:0]   K_EQ      = 4'd14;
  localparam logic [3:0]   K_BKSP    = 4'd15;

  typedef enum logic [2:0] {
    S_ENTRY_A = 3'd0,
    S_ENTRY_B = 3'd1,
    S_EXEC    = 3'd2,
    S_SCAN    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t         state_q, state_d, ret_q, ret_d;
  logic [W-1:0]   digits_q, digits_d, rega_q, rega_d, regb_q, regb_d;
  logic [W-1:0]   scan_q, scan_d, bq_q, bq_d;
  logic [2*W-1:0] acc_q, acc_d, sh_q, sh_d;
  logic [3:0]     op_q, op_d, nop_q, nop_d;
  logic           fresh_q, fresh_d, neg_q, neg_d, chain_q, chain_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W+3:0]   app;
  logic [2*W-1:0] mul_acc, res;
  logic           res_neg, fin, div0, do_scan, do_err, do_exec;
  logic [3:0]     scan_mod;

  // Candidate values: appended entry and one shift-add multiply step
  always_comb begin
    app     = ({4'b0000, digits_q} * (W+4)'(10)) + {{W{1'b0}}, bus.cmd};
    mul_acc = acc_q + (bq_q[0] ? sh_q : '0);
  end

`ifdef CALC_DIV_EN
  logic [W:0]   div_sh, div_rem;
  logic [W-1:0] div_q;

  // One restoring-divide step: remainder lives in acc, quotient shifts into bq
  always_comb begin
    div_sh = {acc_q[W-1:0], bq_q[W-1]};
    if (div_sh >= {1'b0, regb_q}) begin
      div_rem = div_sh - {1'b0, regb_q};
      div_q   = {bq_q[W-2:0], 1'b1};
    end else begin
      div_rem = div_sh;
      div_q   = {bq_q[W-2:0], 1'b0};
    end
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;   ret_d   = ret_q;
    digits_d = digits_q;  rega_d  = rega_q;  regb_d = regb_q;
    scan_d   = scan_q;    bq_d    = bq_q;
    acc_d    = acc_q;     sh_d    = sh_q;
    op_d     = op_q;      nop_d   = nop_q;
    fresh_d  = fresh_q;   neg_d   = neg_q;   chain_d = chain_q;
    pos_d    = pos_q;     cnt_d   = cnt_q;
    do_scan  = 1'b0;      do_err  = 1'b0;    do_exec = 1'b0;
    fin      = 1'b0;      res     = '0;      res_neg = 1'b0;  div0 = 1'b0;

    case (state_q)
      S_ENTRY_A, S_ENTRY_B: begin
        if (bus.cmd_valid) begin
          if (bus.cmd <= 4'd9) begin
            ret_d = state_q;
            if (fresh_q) begin
              digits_d = W'(bus.cmd);
              fresh_d  = 1'b0;
              neg_d    = 1'b0;
              do_scan  = 1'b1;
            end else if (app <= LIMIT) begin
              digits_d = app[W-1:0];
              do_scan  = 1'b1;
            end
          end else if (bus.cmd == K_BKSP) begin
            ret_d    = state_q;
            digits_d = digits_q / W'(10);
            fresh_d  = 1'b0;
            do_scan  = 1'b1;
          end
`ifndef CALC_DIV_EN
          else if (bus.cmd == K_DIV) begin
            do_err = 1'b1;
          end
`endif
          else if (state_q == S_ENTRY_A) begin
            // equals with no pending operator is simply ignored
            if (bus.cmd != K_EQ) begin
              if (neg_q) begin
                do_err = 1'b1;
              end else begin
                rega_d   = digits_q;
                op_d     = bus.cmd;
                digits_d = '0;
                ret_d    = S_ENTRY_B;
                do_scan  = 1'b1;
              end
            end
          end else begin
            if (neg_q) begin
              do_err = 1'b1;
            end else begin
              regb_d  = digits_q;
              chain_d = (bus.cmd != K_EQ);
              nop_d   = bus.cmd;
              do_exec = 1'b1;
            end
          end
        end
      end

      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        case (op_q)
          K_ADD: begin
            fin = 1'b1;
            res = {{(W-1){1'b0}}, {1'b0, rega_q} + {1'b0, regb_q}};
          end
          K_SUB: begin
            fin = 1'b1;
            if (regb_q > rega_q) begin
              res     = {{W{1'b0}}, regb_q - rega_q};
              res_neg = 1'b1;
            end else begin
              res = {{W{1'b0}}, rega_q - regb_q};
            end
          end
          K_MUL: begin
            acc_d = mul_acc;
            sh_d  = sh_q << 1;
            bq_d  = bq_q >> 1;
            fin   = (cnt_q == CW'(W-1));
            res   = mul_acc;
          end
`ifdef CALC_DIV_EN
          K_DIV: begin
            acc_d = {{(W-1){1'b0}}, div_rem};
            bq_d  = div_q;
            fin   = (cnt_q == CW'(W-1));
            res   = {{W{1'b0}}, div_q};
            div0  = (regb_q == '0);
          end
`endif
          default: fin = 1'b1;
        endcase

        // Result is checked only once the loop completes; a bad result never scans
        if (fin) begin
          if ((res > (2*W)'(LIMIT)) || div0) begin
            do_err = 1'b1;
          end else begin
            neg_d   = res_neg;
            do_scan = 1'b1;
            if (chain_q) begin
              rega_d   = res[W-1:0];
              op_d     = nop_q;
              digits_d = '0;
              ret_d    = S_ENTRY_B;
            end else begin
              digits_d = res[W-1:0];
              fresh_d  = 1'b1;
              ret_d    = S_ENTRY_A;
            end
          end
        end
      end

      S_SCAN: begin
        scan_d = scan_q / W'(10);
        if (pos_q == PW'(NDIG-1)) begin
          pos_d   = '0;
          state_d = ret_q;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end

      S_ERR: pos_d = (pos_q == PW'(NDIG-1)) ? '0 : pos_q + 1'b1;

      default: state_d = S_ERR;
    endcase

    if (do_exec) begin
      state_d = S_EXEC;
      cnt_d   = '0;
      acc_d   = '0;
      sh_d    = {{W{1'b0}}, rega_q};
      bq_d    = (op_q == K_DIV) ? rega_q : digits_q;
    end

    if (do_err) begin
      state_d  = S_ERR;
      digits_d = '0;
      neg_d    = 1'b0;
      pos_d    = '0;
    end else if (do_scan) begin
      state_d = S_SCAN;
      scan_d  = digits_d;
      pos_d   = '0;
    end
  end

  // State and datapath registers; reset lands in SCAN showing zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_SCAN;   ret_q   <= S_ENTRY_A;
      digits_q <= '0;       rega_q  <= '0;  regb_q <= '0;
      scan_q   <= '0;       bq_q    <= '0;
      acc_q    <= '0;       sh_q    <= '0;
      op_q     <= '0;       nop_q   <= '0;
      fresh_q  <= 1'b0;     neg_q   <= 1'b0; chain_q <= 1'b0;
      pos_q    <= '0;       cnt_q   <= '0;
    end else begin
      state_q  <= state_d;  ret_q   <= ret_d;
      digits_q <= digits_d; rega_q  <= rega_d; regb_q <= regb_d;
      scan_q   <= scan_d;   bq_q    <= bq_d;
      acc_q    <= acc_d;    sh_q    <= sh_d;
      op_q     <= op_d;     nop_q   <= nop_d;
      fresh_q  <= fresh_d;  neg_q   <= neg_d;  chain_q <= chain_d;
      pos_q    <= pos_d;    cnt_q   <= cnt_d;
    end
  end

  // Status and display digit decode from the current state
  always_comb begin
    scan_mod   = 4'(scan_q % W'(10));
    bus.status = ST_BUSY;
    bus.data   = 4'd0;
    case (state_q)
      S_ENTRY_A, S_ENTRY_B: bus.status = ST_READY;
      S_SCAN:               bus.data   = scan_mod;
      S_ERR: begin
        bus.status = ST_ERROR;
        bus.data   = 4'hE;
      end
      default: ;
    endcase
  end

  assign bus.pos    = pos_q;
  assign bus.digits = digits_q;
  assign bus.neg    = neg_q;
endmodule
`default_nettype wire

// File: doc/calc_param.md
# calc_param

Parametrised second-generation decimal calculator core. Accepts one 4-bit key command per handshake, builds decimal operands, executes add/subtract/multiply/divide (multi-cycle shift-add and restoring divide), chains operators, and time-multiplexes the BCD digits of the current value onto a digit-scan display port. Sits between the keypad decoder and the multiplexed 7-segment driver.

## Interface
- NDIG, 8, display digits; the entry and result limit is 10^NDIG-1.
- W, 27, datapath width in bits; must satisfy 2^W > 10^NDIG-1.
- PW, max(1,clog2(NDIG)), width of pos (localparam).
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- cmd  in  4  key code: 0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 backspace.
- cmd_valid  in  1  cmd is sampled only when cmd_valid=1 and status=10.
- status  out  2  00 error, 01 busy, 10 ready.
- data  out  4  BCD digit for display position pos; 4'hE in error.
- pos  out  PW  display position currently driven (0 = least significant digit).
- digits  out  W  current entry or result magnitude.
- neg  out  1  current result is negative.

## Operation
- States: ENTRY_A, ENTRY_B, EXEC, SCAN, ERR. Registers: regA, regB, op, fresh, neg.
- Accepted command: cmd_valid & status==10. Commands offered while busy or in error are dropped; there is no queue.
- Digit (0-9): if fresh=1, digits<=cmd and fresh, neg<=0. Otherwise, if digits*10+cmd <= 10^NDIG-1, digits<=digits*10+cmd; else ignore the key, stay ready, no SCAN. An applied digit goes to SCAN.
- Backspace: digits<=digits/10, fresh<=0, go to SCAN.
- Operator (10-13) in ENTRY_A:
  - If neg=1, go to ERR.
  - Else regA<=digits, op<=cmd, digits<=0, enter ENTRY_B via SCAN.
- Operator in ENTRY_B (chaining): regB<=digits, go to EXEC with the pending op. The result becomes regA, op<=new cmd, digits<=0, then SCAN, then ENTRY_B.
- Equals in ENTRY_B: regB<=digits, go to EXEC, digits<=result, fresh<=1, then SCAN, then ENTRY_A.
- Equals in ENTRY_A: ignored.
- Arithmetic:
  - add: A+B.
  - sub: |A-B|, with neg=1 when B>A.
  - mul: W-iteration shift-add into a 2W-bit accumulator.
  - div: W-iteration restoring divide; quotient truncated, remainder discarded.
- Error conditions go to ERR:
  - result > 10^NDIG-1
  - divide by zero
  - equals or chained operator while neg=1
- SCAN: load scan register with digits. Each cycle: data<=scan%10, scan<=scan/10, pos increments from 0 to NDIG-1. Leading zeros are displayed. After pos=NDIG-1, status<=10.
- ERR: status=00, digits=0, neg=0. pos cycles 0..NDIG-1 continuously with data=4'hE. Sticky until reset.

## Timing
- Reset values: status=01, data=0, pos=0, digits=0, neg=0, fresh=0, regA=regB=op=0. State is SCAN, so the first NDIG cycles after release display zeros, then status=10.
- An accept at edge N makes status=01 at N+1.
- Busy length after an accept:
  - digit or backspace: NDIG cycles.
  - operator from ENTRY_A: NDIG cycles.
  - equals or chained operator, add/sub: 1+NDIG cycles.
  - equals or chained operator, mul/div: W+NDIG cycles.
- data/pos pair: valid on the same cycle during SCAN; data=0 and pos=0 while in EXEC.
- An error is detected at the end of EXEC. status=00 from the next cycle; no SCAN of the partial result.
- Reset asserted mid-EXEC or mid-SCAN aborts immediately (asynchronous); reset values apply.

## Configuration
- CALC_DIV_EN defined: the divider is present and cmd 13 divides.
- CALC_DIV_EN undefined: no divider logic; an accepted cmd 13 goes straight to ERR.

## Test plan
- Reset release with NDIG=8 -> status=01 for 8 cycles, pos 0..7 with data=0, then status=10.
- 1,2,add,3,4,equals -> digits=46, busy 9 cycles, scan data 6,4,0,0,0,0,0,0, status 10.
- 7,sub,9,equals -> digits=2, neg=1. A following add -> status=00, data=4'hE.
- 12345,mul,678,equals -> digits=8369910 after 35 busy cycles. Chaining 5,add,3,mul,2,equals -> 16.
- 99999999,mul,2,equals -> status=00, data=4'hE. Offering a 9-digit entry -> ninth key ignored.
- CALC_DIV_EN set: 100,div,7,equals -> 14; 100,div,0,equals -> error. CALC_DIV_EN unset: cmd 13 -> error.
